// File: rtl/lane_adder_pkg.sv
// lane_adder_pkg: shared constants and helpers for the lane adder pipeline.
//   clog2    - ceiling log2, used to size the tree depth
//   lvl_cnt  - number of terms alive at a given tree level
//   wi_of    - internal width W + clog2(N_OPS) + 1 (exact, no overflow)
//   sat_max / sat_min - signed W-bit saturation bounds
//   `LANE_OP_IDX(l, k, n, w) - bit offset of lane l, operand k in the ops bus
// Optional feature macro (consumed by the top): LANE_ADDER_SAT_COUNT_EN.

`ifndef LANE_OP_IDX
`define LANE_OP_IDX(l, k, n, w) ((((l) * (n)) + (k)) * (w))
`endif

package lane_adder_pkg;

  localparam int unsigned W_DEF     = 6;
  localparam int unsigned N_OPS_DEF = 3;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Terms remaining after j pairwise levels of an n-input tree.
  function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned j);
    return (n + (32'd1 << j) - 32'd1) >> j;
  endfunction

  function automatic int unsigned wi_of(input int unsigned w, input int unsigned n);
    return w + clog2(n) + 1;
  endfunction

  function automatic int sat_max(input int unsigned w);
    return int'((32'd1 << (w - 1)) - 32'd1);
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -int'(32'd1 << (w - 1));
  endfunction

  localparam int unsigned WI_DEF      = wi_of(W_DEF, N_OPS_DEF);
  localparam int          SAT_MAX_DEF = sat_max(W_DEF);
  localparam int          SAT_MIN_DEF = sat_min(W_DEF);

endpackage

// File: rtl/lane_adder_tree.sv
// lane_adder_tree: one lane, N_OPS signed operands summed through a registered
// pairwise tree with saturation on the final level.
//   clk, rst (async active-low), adv (advance enable, holds all stages when 0)
//   sub_mode - negate the last operand before the tree
//   ops      - operand k at [k*W +: W]
//   sum      - saturated W-bit result, registered
//   clip     - (LANE_ADDER_SAT_COUNT_EN only) result of this beat was clipped

module lane_adder_tree
  import lane_adder_pkg::*;
#(
  parameter int unsigned W     = 6,
  parameter int unsigned N_OPS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 sub_mode,
  input  logic [N_OPS*W-1:0]   ops,
  output logic [W-1:0]         sum
`ifdef LANE_ADDER_SAT_COUNT_EN
  ,
  output logic                 clip
`endif
);

  localparam int unsigned D  = clog2(N_OPS);
  localparam int unsigned WI = wi_of(W, N_OPS);
  localparam logic signed [WI-1:0] SMAX = WI'(sat_max(W));
  localparam logic signed [WI-1:0] SMIN = WI'(sat_min(W));

  genvar j, i;

  // Level 0 is combinational (extend/negate); levels 1..D-1 registered;
  // level D is the combinational final add feeding the saturating register.
  for (j = 0; j <= D; j++) begin : g_lvl
    localparam int unsigned CNT = lvl_cnt(N_OPS, j);
    logic signed [WI-1:0] term [CNT];

    if (j == 0) begin : g_in
      for (i = 0; i < CNT; i++) begin : g_op
        logic signed [W-1:0] op;
        assign op = ops[i*W +: W];
        // Negation happens in WI bits so -2**(W-1) negates exactly.
        if (i == N_OPS - 1) begin : g_last
          assign term[i] = sub_mode ? -WI'(op) : WI'(op);
        end else begin : g_plain
          assign term[i] = WI'(op);
        end
      end
    end else begin : g_add
      localparam int unsigned PCNT = lvl_cnt(N_OPS, j - 1);
      for (i = 0; i < CNT; i++) begin : g_node
        logic signed [WI-1:0] nxt;
        if (2 * i + 1 < PCNT) begin : g_pair
          assign nxt = g_lvl[j-1].term[2*i] + g_lvl[j-1].term[2*i+1];
        end else begin : g_pass
          assign nxt = g_lvl[j-1].term[2*i];
        end

        if (j < D) begin : g_reg
          logic signed [WI-1:0] q;
          always_ff @(posedge clk or negedge rst) begin
            if (!rst)     q <= '0;
            else if (adv) q <= nxt;
          end
          assign term[i] = q;
        end else begin : g_fin
          assign term[i] = nxt;
        end
      end
    end
  end

  logic signed [WI-1:0] res;
  logic [W-1:0]         sat_c;
  logic                 clip_c;

  assign res = g_lvl[D].term[0];

  // Clamp the exact result into the W-bit signed range.
  always_comb begin
    sat_c  = res[W-1:0];
    clip_c = 1'b0;
    if (res > SMAX) begin
      sat_c  = SMAX[W-1:0];
      clip_c = 1'b1;
    end else if (res < SMIN) begin
      sat_c  = SMIN[W-1:0];
      clip_c = 1'b1;
    end
  end

`ifdef LANE_ADDER_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum  <= '0;
      clip <= 1'b0;
    end else if (adv) begin
      sum  <= sat_c;
      clip <= clip_c;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     sum <= '0;
    else if (adv) sum <= sat_c;
  end
`endif

endmodule

// File: rtl/lane_adder_pipe.sv
// lane_adder_pipe: WC independent lanes of N_OPS-operand saturating adders
// behind a valid/ready handshake with full-pipeline stall.
//   clk, rst (async active-low)
//   in_valid / in_ready   - input beat handshake (in_ready combinational)
//   sub_mode              - per beat: subtract the last operand
//   ops                   - lane l operand k at `LANE_OP_IDX(l, k, N_OPS, W)
//   out_valid / out_ready - result beat handshake
//   sum                   - lane l result at [l*W +: W]
//   sat_cnt               - (LANE_ADDER_SAT_COUNT_EN only) saturating count of
//                           retired beats with at least one clipped lane

module lane_adder_pipe
  import lane_adder_pkg::*;
#(
  parameter int unsigned WC    = 32,
  parameter int unsigned W     = 6,
  parameter int unsigned N_OPS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sub_mode,
  input  logic [WC*N_OPS*W-1:0]   ops,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WC*W-1:0]         sum
`ifdef LANE_ADDER_SAT_COUNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int unsigned D = clog2(N_OPS);

  logic         adv;
  logic [D-1:0] vld;

  // Whole pipe moves when the output slot is empty or being drained.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv & rst;
  assign out_valid = vld[D-1];

  // Valid bit shift chain, one bit per tree register level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     vld <= '0;
    else if (adv) vld <= (vld << 1) | D'(in_valid);
  end

`ifdef LANE_ADDER_SAT_COUNT_EN
  logic [WC-1:0] clip_vec;
`endif

  for (genvar l = 0; l < WC; l++) begin : g_lane
    lane_adder_tree #(
      .W     (W),
      .N_OPS (N_OPS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .sub_mode (sub_mode),
      .ops      (ops[`LANE_OP_IDX(l, 0, N_OPS, W) +: N_OPS*W]),
      .sum      (sum[l*W +: W])
`ifdef LANE_ADDER_SAT_COUNT_EN
      ,
      .clip     (clip_vec[l])
`endif
    );
  end

`ifdef LANE_ADDER_SAT_COUNT_EN
  // Count clipped beats as they retire; stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && (|clip_vec) && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lane_adder_pipe.sv
// Directed bench for lane_adder_pipe (WC=4, W=6, N_OPS=3).
// Saturation-counter steps are included when LANE_ADDER_SAT_COUNT_EN is defined.

module tb_lane_adder_pipe;

  localparam int unsigned WC    = 4;
  localparam int unsigned W     = 6;
  localparam int unsigned N_OPS = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  sub_mode = 1'b0;
  logic                  out_ready = 1'b1;
  logic [WC*N_OPS*W-1:0] ops = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [WC*W-1:0]       sum;
`ifdef LANE_ADDER_SAT_COUNT_EN
  logic [15:0]           sat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lane_adder_pipe #(
    .WC    (WC),
    .W     (W),
    .N_OPS (N_OPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub_mode  (sub_mode),
    .ops       (ops),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef LANE_ADDER_SAT_COUNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input int a, input int b, input int c);
    ops[(l*N_OPS+0)*W +: W] = W'(a);
    ops[(l*N_OPS+1)*W +: W] = W'(b);
    ops[(l*N_OPS+2)*W +: W] = W'(c);
  endtask

  // Beat i: lane l gets (i, l, 1), sum mode -> i + l + 1.
  task automatic load_seq(input int i);
    sub_mode = 1'b0;
    for (int l = 0; l < WC; l++) set_lane(l, i, l, 1);
  endtask

  function automatic logic [5:0] lane_of(input int l);
    return sum[l*W +: W];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_in;
    int next_out;
    int n;
    logic acc;
    logic [0:10] exp_ov3;
    logic [0:10] exp_ir3;
    logic [0:5]  exp_ov4;

    // Reset state
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(1'b0));
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_sum", 32'(sum), 32'd0);
`ifdef LANE_ADDER_SAT_COUNT_EN
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'(1'b1));

    // 1: plain sum, two-cycle latency, single-cycle out_valid
    ops = '0;
    set_lane(0, 10, 20, -5);
    sub_mode = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_lat1_ov", 32'(out_valid), 32'(1'b0));
    tick();
    chk("t1_ov", 32'(out_valid), 32'(1'b1));
    chk("t1_lane0", 32'(lane_of(0)), 32'(6'd25));
    chk("t1_lane1", 32'(lane_of(1)), 32'(6'd0));
    tick();
    chk("t1_ov_drop", 32'(out_valid), 32'(1'b0));

    // 2: subtract mode and saturation, two back-to-back beats
    set_lane(0, 0, 0, -32);
    set_lane(1, 10, 20, 5);
    set_lane(2, 31, 31, -32);
    set_lane(3, -32, -32, -32);
    sub_mode = 1'b1;
    in_valid = 1'b1;
    tick();
    set_lane(0, 10, 20, -5);
    set_lane(1, 31, 31, 31);
    set_lane(2, 1, -2, 3);
    set_lane(3, -32, -32, -32);
    sub_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t2a_ov", 32'(out_valid), 32'(1'b1));
    chk("t2a_lane0_negmin", 32'(lane_of(0)), 32'(6'd31));
    chk("t2a_lane1", 32'(lane_of(1)), 32'(6'd25));
    chk("t2a_lane2_satpos", 32'(lane_of(2)), 32'(6'd31));
    chk("t2a_lane3_exact", 32'(lane_of(3)), 32'(6'h20));
`ifdef LANE_ADDER_SAT_COUNT_EN
    chk("t2a_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    tick();
    chk("t2b_ov", 32'(out_valid), 32'(1'b1));
    chk("t2b_lane0", 32'(lane_of(0)), 32'(6'd25));
    chk("t2b_lane1_satpos", 32'(lane_of(1)), 32'(6'd31));
    chk("t2b_lane2", 32'(lane_of(2)), 32'(6'd2));
    chk("t2b_lane3_satneg", 32'(lane_of(3)), 32'(6'h20));
`ifdef LANE_ADDER_SAT_COUNT_EN
    chk("t2b_sat_cnt", 32'(sat_cnt), 32'd1);
`endif
    tick();
    chk("t2_ov_drop", 32'(out_valid), 32'(1'b0));
`ifdef LANE_ADDER_SAT_COUNT_EN
    chk("t2_sat_cnt", 32'(sat_cnt), 32'd2);
`endif

    // 3: five-beat stream with out_ready low in cycles 3..5
    exp_ov3  = 11'b00111111110;
    exp_ir3  = 11'b11000111111;
    next_in  = 0;
    next_out = 0;
    for (int c = 1; c <= 11; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (next_in < 5) begin
        load_seq(next_in);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("t3_in_ready_c%0d", c), 32'(in_ready), 32'(exp_ir3[c-1]));
      chk($sformatf("t3_out_valid_c%0d", c), 32'(out_valid), 32'(exp_ov3[c-1]));
      if (c >= 3 && c <= 5) begin
        chk($sformatf("t3_hold_c%0d", c), 32'(lane_of(0)), 32'(6'd1));
      end
      if (out_valid && out_ready) begin
        for (int l = 0; l < WC; l++) begin
          chk($sformatf("t3_beat%0d_lane%0d", next_out, l), 32'(lane_of(l)),
              32'(W'(next_out + l + 1)));
        end
        next_out++;
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) next_in++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t3_accepted", 32'(next_in), 32'd5);
    chk("t3_retired", 32'(next_out), 32'd5);

    // 4: alternating valid, bubbles never show as out_valid
    exp_ov4 = 6'b001010;
    for (int c = 1; c <= 6; c++) begin
      load_seq(c);
      in_valid = (c <= 4) && (c % 2 == 1);
      #1;
      chk($sformatf("t4_out_valid_c%0d", c), 32'(out_valid), 32'(exp_ov4[c-1]));
      if (out_valid) begin
        chk($sformatf("t4_lane0_c%0d", c), 32'(lane_of(0)), 32'(W'(c - 1)));
      end
      tick();
    end
    in_valid = 1'b0;

    // 5: reset with two beats in flight
    load_seq(7);
    in_valid = 1'b1;
    tick();
    load_seq(8);
    tick();
    in_valid = 1'b0;
    chk("t5_pre_ov", 32'(out_valid), 32'(1'b1));
    rst = 1'b0;
    #1;
    chk("t5_rst_ov", 32'(out_valid), 32'(1'b0));
    chk("t5_rst_sum", 32'(sum), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'(1'b0));
`ifdef LANE_ADDER_SAT_COUNT_EN
    chk("t5_rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t5_no_stale_%0d", c), 32'(out_valid), 32'(1'b0));
    end
    load_seq(9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_new_lat1", 32'(out_valid), 32'(1'b0));
    tick();
    chk("t5_new_ov", 32'(out_valid), 32'(1'b1));
    chk("t5_new_lane3", 32'(lane_of(3)), 32'(6'd13));
    tick();
    chk("t5_new_drop", 32'(out_valid), 32'(1'b0));

`ifdef LANE_ADDER_SAT_COUNT_EN
    // 6: counter sticks at all-ones
    sub_mode = 1'b0;
    for (int l = 0; l < WC; l++) set_lane(l, 31, 31, 31);
    in_valid = 1'b1;
    n = 0;
    while (n < 70000 && sat_cnt !== 16'hFFFF) begin
      tick();
      n++;
    end
    chk("t6_sat_cnt_full", 32'(sat_cnt), 32'h0000FFFF);
    chk("t6_ticks_to_full", 32'(n), 32'd65537);
    for (int c = 0; c < 4; c++) tick();
    chk("t6_sat_cnt_hold", 32'(sat_cnt), 32'h0000FFFF);
    in_valid = 1'b0;
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
